// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM states, instruction width and queue entry layout.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: imem req/ack, branch redirect, and the valid/ready hand-off to decode.
interface instruction_fetch_unit_if #(
  parameter int PC_WIDTH = 5
);
  import fetch_pkg::*;

  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_rdata;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                instr_valid;
  logic                instr_ready;
  logic [INSTR_W-1:0]  instr_data;
  logic [PC_WIDTH-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of {pc, instr}; flush clears it and wins over push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  entry_t           i_push_dat,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count,
  output entry_t           o_head
);
  localparam int PTR_W = $clog2(DEPTH);

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_W'(1);
      if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_push_dat;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the PC, issues one-at-a-time imem fetches, queues returned words for decode,
// and on redirect flushes the queue and discards any stale in-flight response.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH = PC_W,
  parameter int                  DEPTH    = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                reset,
  instruction_fetch_unit_if.master bus
);
  localparam int               CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  if (PC_WIDTH != PC_W) begin : g_pc_width_check
    $error("PC_WIDTH must match fetch_pkg::PC_W");
  end

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_addr;
  logic                r_req;

  logic [CNT_W-1:0]    w_count;
  logic [CNT_W-1:0]    w_after_pop;
  entry_t              w_head;
  logic                w_valid;
  logic                w_pop;
  logic                w_ack;
  logic                w_push;
  logic                w_space;
  logic                w_space_push;
  logic [PC_WIDTH-1:0] w_pc_inc;

  assign w_valid      = (w_count != '0);
  assign w_pop        = w_valid && bus.instr_ready;
  assign w_ack        = bus.imem_ack && r_req;
  assign w_push       = (r_state == WAIT) && w_ack && !bus.redirect_valid;
  assign w_after_pop  = w_count - CNT_W'(w_pop);
  assign w_space      = w_after_pop < FULL;
  assign w_space_push = (w_after_pop + CNT_W'(1)) < FULL;
  assign w_pc_inc     = r_pc + PC_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_pc <= bus.redirect_pc;
      // A request still in flight must complete before the target can be fetched.
      if (r_state == IDLE || w_ack) begin
        r_state <= WAIT;
        r_req   <= 1'b1;
        r_addr  <= bus.redirect_pc;
      end else begin
        r_state <= DROP;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_space) begin
            r_state <= WAIT;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        WAIT: begin
          if (w_ack) begin
            r_pc   <= w_pc_inc;
            r_addr <= w_pc_inc;
            if (!w_space_push) begin
              r_state <= IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        DROP: begin
          if (w_ack) begin
            r_addr <= r_pc;
            if (w_space) begin
              r_state <= WAIT;
            end else begin
              r_state <= IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat ('{pc: r_pc, instr: bus.imem_rdata}),
    .i_pop      (w_pop),
    .i_flush    (bus.redirect_valid),
    .o_count    (w_count),
    .o_head     (w_head)
  );

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instr_valid = w_valid;
  assign bus.instr_data  = w_valid ? w_head.instr : '0;
  assign bus.instr_pc    = w_valid ? w_head.pc : '0;
endmodule
